// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch with 2-entry queue; define INST_FETCH_COUNT_EN to add the num_inst counter
module inst_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        reset_cpu_n,
  input  logic        cpu_enable,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [7:0]  redirect_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst,
  output logic [7:0]  inst_pc,
  output logic [7:0]  PC_below8bit
`ifdef INST_FETCH_COUNT_EN
  ,
  output logic [15:0] num_inst
`endif
);

  logic [7:0]  pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        inflight_q, inflight_d;
  logic        drop_q, drop_d;
  logic [7:0]  req_addr_q, req_addr_d;
  logic [7:0]  fifo_pc_q [2];
  logic [7:0]  fifo_pc_d [2];
  logic [15:0] fifo_inst_q [2];
  logic [15:0] fifo_inst_d [2];

  logic       pop;
  logic       push;
  logic [2:0] occupancy;

  // Handshake, request throttling and head-of-queue outputs
  always_comb begin
    inst_valid   = cpu_enable & (count_q != 2'd0);
    pop          = inst_valid & inst_ready;
    // Slots already committed (queued plus in flight) once this cycle's pop retires.
    occupancy    = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    imem_req     = reset_cpu_n & cpu_enable & ~redirect & (occupancy < 3'd2);
    imem_addr    = pc_q;
    PC_below8bit = pc_q;
    inst         = fifo_inst_q[rd_ptr_q];
    inst_pc      = fifo_pc_q[rd_ptr_q];
    // A response landing in a redirect cycle belongs to the abandoned path.
    push         = inflight_q & ~drop_q & ~redirect;
  end

  // Next-state for PC, in-flight tracking and the queue
  always_comb begin
    pc_d        = pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    inflight_d  = imem_req;
    req_addr_d  = req_addr_q;
    drop_d      = redirect & inflight_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;

    if (imem_req) begin
      req_addr_d = pc_q;
    end

    if (push) begin
      fifo_pc_d[wr_ptr_q]   = req_addr_q;
      fifo_inst_d[wr_ptr_q] = imem_rdata;
    end

    if (redirect) begin
      // Any pop this cycle has already been seen by decode; the flush follows it.
      pc_d     = redirect_target;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (imem_req) begin
        pc_d = pc_q + 8'd1;
      end
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_cpu_n) begin
    if (!reset_cpu_n) begin
      pc_q        <= RESET_PC;
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      inflight_q  <= 1'b0;
      drop_q      <= 1'b0;
      req_addr_q  <= 8'h00;
      fifo_pc_q   <= '{default: 8'h00};
      fifo_inst_q <= '{default: 16'h0000};
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      req_addr_q  <= req_addr_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_inst_q <= fifo_inst_d;
    end
  end

`ifdef INST_FETCH_COUNT_EN
  logic [15:0] num_inst_q, num_inst_d;

  // Delivered-instruction count, wraps naturally at 16 bits
  always_comb begin
    num_inst_d = num_inst_q + {15'd0, pop};
  end

  // Counter register
  always_ff @(posedge clk or negedge reset_cpu_n) begin
    if (!reset_cpu_n) begin
      num_inst_q <= 16'h0000;
    end else begin
      num_inst_q <= num_inst_d;
    end
  end

  assign num_inst = num_inst_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - randomized bench for inst_fetch against a queue-based reference model
module tb_inst_fetch;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic        clk;
  logic        reset_cpu_n;
  logic        cpu_enable;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [7:0]  redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [7:0]  inst_pc;
  logic [7:0]  PC_below8bit;
`ifdef INST_FETCH_COUNT_EN
  logic [15:0] num_inst;
`endif

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .reset_cpu_n(reset_cpu_n),
    .cpu_enable(cpu_enable),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .PC_below8bit(PC_below8bit)
`ifdef INST_FETCH_COUNT_EN
    ,
    .num_inst(num_inst)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [256];

  // Instruction memory: data for a request appears the following cycle; garbage otherwise.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr];
    else          imem_rdata <= 16'($urandom);
  end

  typedef struct {
    logic [7:0] pc;
    int         cyc;
  } ent_t;

  ent_t        q[$];
  logic [7:0]  m_pc;
  logic [15:0] m_num;
  int          cyc;
  int          n_checks;
  int          n_pass;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  // One clock: check outputs at the falling edge against the model, then advance the model.
  task automatic tick();
    bit hv;
    bit exp_valid;
    bit pop;
    bit exp_req;
    @(negedge clk);
    if (!reset_cpu_n) begin
      check_eq("rst_req", 32'(imem_req), 32'd0);
      check_eq("rst_valid", 32'(inst_valid), 32'd0);
      check_eq("rst_inst", 32'(inst), 32'h0);
      check_eq("rst_inst_pc", 32'(inst_pc), 32'h0);
      check_eq("rst_pc_led", 32'(PC_below8bit), 32'(RESET_PC));
`ifdef INST_FETCH_COUNT_EN
      check_eq("rst_num", 32'(num_inst), 32'd0);
`endif
      q.delete();
      m_pc  = RESET_PC;
      m_num = 16'h0;
    end else begin
      // An instruction becomes visible two cycles after its request.
      hv        = (q.size() != 0) && (cyc - q[0].cyc >= 2);
      exp_valid = cpu_enable && hv;
      check_eq("inst_valid", 32'(inst_valid), 32'(exp_valid));
      check_eq("imem_addr", 32'(imem_addr), 32'(m_pc));
      check_eq("pc_led", 32'(PC_below8bit), 32'(m_pc));
`ifdef INST_FETCH_COUNT_EN
      check_eq("num_inst", 32'(num_inst), 32'(m_num));
`endif
      if (exp_valid) begin
        check_eq("inst_pc", 32'(inst_pc), 32'(q[0].pc));
        check_eq("inst", 32'(inst), 32'(mem[q[0].pc]));
      end
      pop     = exp_valid && inst_ready;
      exp_req = cpu_enable && !redirect && ((q.size() - int'(pop)) < 2);
      check_eq("imem_req", 32'(imem_req), 32'(exp_req));
      if (pop) begin
        void'(q.pop_front());
        m_num = m_num + 16'd1;
      end
      if (redirect) begin
        q.delete();
        m_pc = redirect_target;
      end else if (exp_req) begin
        q.push_back('{pc: m_pc, cyc: cyc});
        m_pc = m_pc + 8'd1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse: outputs must take reset values without waiting for a clock.
  task automatic start_clean();
    reset_cpu_n = 1'b0;
    redirect    = 1'b0;
    #1;
    check_eq("async_req", 32'(imem_req), 32'd0);
    check_eq("async_valid", 32'(inst_valid), 32'd0);
    check_eq("async_inst", 32'(inst), 32'h0);
    check_eq("async_inst_pc", 32'(inst_pc), 32'h0);
    check_eq("async_pc_led", 32'(PC_below8bit), 32'(RESET_PC));
    tick();
    tick();
    reset_cpu_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    m_pc     = RESET_PC;
    m_num    = 16'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h6000 + 16'(i);
    reset_cpu_n     = 1'b1;
    cpu_enable      = 1'b0;
    inst_ready      = 1'b0;
    redirect        = 1'b0;
    redirect_target = 8'h00;
    #3;

    // Streaming from reset at full rate
    start_clean();
    cpu_enable = 1'b1;
    inst_ready = 1'b1;
    repeat (10) tick();

    // Decode back-pressure fills the queue, then drains without gaps
    start_clean();
    cpu_enable = 1'b1;
    inst_ready = 1'b1;
    repeat (2) tick();
    inst_ready = 1'b0;
    repeat (5) tick();
    inst_ready = 1'b1;
    repeat (6) tick();

    // Redirect while the request for 8'h11 is outstanding
    start_clean();
    cpu_enable = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 40 && m_pc != 8'h12; i++) tick();
    if (m_pc != 8'h12) check_eq("timeout_pc11", 32'(imem_addr), 32'h12);
    redirect        = 1'b1;
    redirect_target = 8'h15;
    tick();
    redirect = 1'b0;
    check_eq("redir_addr", 32'(imem_addr), 32'h15);
    repeat (6) tick();

    // Redirect in the same cycle that 8'h10 is consumed
    start_clean();
    cpu_enable = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (q.size() != 0 && q[0].pc == 8'h10 && cyc - q[0].cyc >= 2) break;
      tick();
    end
    if (!(q.size() != 0 && q[0].pc == 8'h10)) check_eq("timeout_pc10", 32'(inst_pc), 32'h10);
    redirect        = 1'b1;
    redirect_target = 8'h40;
    tick();
    redirect = 1'b0;
    repeat (6) tick();

    // PC wraps from 8'hFF to 8'h00
    redirect        = 1'b1;
    redirect_target = 8'hFD;
    tick();
    redirect = 1'b0;
    repeat (3) tick();
    check_eq("wrap_addr", 32'(imem_addr), 32'h00);
    repeat (3) tick();

    // Reset mid-stream, then restart from RESET_PC
    start_clean();
    repeat (6) tick();

    // Stall for three cycles, then resume in order
    cpu_enable = 1'b0;
    repeat (3) tick();
    cpu_enable = 1'b1;
    repeat (8) tick();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cpu_enable      = ($urandom_range(0, 7) != 0);
      inst_ready      = ($urandom_range(0, 3) != 0);
      redirect        = ($urandom_range(0, 15) == 0);
      redirect_target = 8'($urandom);
      tick();
    end
    redirect = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
